// File: rtl/out_tim_lcar_gen.sv
// Output timing generator: frame start pulse, first-period flag, per-period blanking and period status.
// Optional self-generated (free-run) frame timing is enabled by defining OUT_TIM_FREERUN_EN.
module out_tim_lcar_gen #(
    parameter int PN_W = 11,
    parameter int PL_W = 12,
    parameter int BL_W = 7,
    parameter int WD_W = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_alt,
    input  logic [PN_W-1:0] period_num_m1,
    input  logic [PL_W-1:0] period_len,
    input  logic [PN_W-1:0] long_num,
    input  logic [BL_W-1:0] blank_len,
    input  logic [WD_W-1:0] wd_limit,
    output logic            ov_stp,
    output logic            ovt,
    output logic            blanka,
    output logic            period_stb,
    output logic [PN_W-1:0] period_idx,
    output logic            frame_done,
    output logic            ovr_err,
    output logic            freerun
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            fa_1d, fa_2d;
    logic            ext_edge;
    logic            ov_ext;
    logic [PN_W-1:0] pn_m1_s, long_s;
    logic [PL_W-1:0] plen_s;
    logic [BL_W-1:0] blank_s;
    logic [PL_W-1:0] cnt_q;
    logic [PN_W-1:0] idx_q;
    logic [BL_W-1:0] bcnt_q;
    logic            stb_q, ovt_q, ovr_q;

    logic [PL_W-1:0] plen_in, cur_plen, len_m1;
    logic [PN_W-1:0] cur_long, next_idx;
    logic [BL_W-1:0] cur_blank;
    logic            start, period_end, last, load, long_hit;

    assign ext_edge = fa_1d ^ fa_2d;
    assign start    = ov_stp;

    // Frame detect front end; ov_stp may also come from the watchdog.
`ifdef OUT_TIM_FREERUN_EN
    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;
    logic            freerun_q;

    assign wd_fire = (wd_limit != '0) && (wd_cnt >= wd_limit - WD_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_1d     <= 1'b0;
            fa_2d     <= 1'b0;
            ov_stp    <= 1'b0;
            ov_ext    <= 1'b0;
            wd_cnt    <= '0;
            freerun_q <= 1'b0;
        end else begin
            fa_1d  <= frame_alt;
            fa_2d  <= fa_1d;
            ov_stp <= ext_edge | wd_fire;
            // The first external edge after free-running is a resync, not an overrun.
            ov_ext <= ext_edge & ~freerun_q;
            if (ext_edge || wd_fire) begin
                wd_cnt <= '0;
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (ext_edge) begin
                freerun_q <= 1'b0;
            end else if (wd_fire) begin
                freerun_q <= 1'b1;
            end
        end
    end

    assign freerun = freerun_q;
`else
    logic unused_wd;
    assign unused_wd = ^wd_limit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_1d  <= 1'b0;
            fa_2d  <= 1'b0;
            ov_stp <= 1'b0;
            ov_ext <= 1'b0;
        end else begin
            fa_1d  <= frame_alt;
            fa_2d  <= fa_1d;
            ov_stp <= ext_edge;
            ov_ext <= ext_edge;
        end
    end

    assign freerun = 1'b0;
`endif

    // Frame parameters come straight from the inputs on the start clock, from the shadows otherwise.
    always_comb begin
        plen_in    = (period_len < PL_W'(2)) ? PL_W'(2) : period_len;
        cur_plen   = start ? plen_in : plen_s;
        cur_long   = start ? long_num : long_s;
        cur_blank  = start ? blank_len : blank_s;
        period_end = (state_q == RUN) && (cnt_q == '0);
        last       = (idx_q == pn_m1_s);
        load       = start || (period_end && !last);
        next_idx   = start ? '0 : idx_q + PN_W'(1);
        long_hit   = (next_idx < cur_long);
        len_m1     = cur_plen - PL_W'(1) + {{(PL_W-1){1'b0}}, long_hit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state defaults to the current state first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (period_end && last) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        frame_done = (state_q == IDLE);
        ovt        = ov_stp | ovt_q;
        blanka     = (bcnt_q != '0);
    end

    assign period_stb = stb_q;
    assign period_idx = idx_q;
    assign ovr_err    = ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pn_m1_s <= '0;
            plen_s  <= PL_W'(2);
            long_s  <= '0;
            blank_s <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            stb_q   <= 1'b0;
            ovt_q   <= 1'b0;
            bcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (start) begin
                pn_m1_s <= period_num_m1;
                plen_s  <= plen_in;
                long_s  <= long_num;
                blank_s <= blank_len;
            end

            if (load) begin
                cnt_q <= len_m1;
                idx_q <= next_idx;
            end else if (state_q == RUN && cnt_q != '0) begin
                cnt_q <= cnt_q - PL_W'(1);
            end

            stb_q <= load;

            if (start) begin
                ovt_q <= 1'b1;
            end else if (period_end && (idx_q == PN_W'(1) || last)) begin
                ovt_q <= 1'b0;
            end

            // Blank restarts on every period start and drains out after the frame ends.
            if (load) begin
                bcnt_q <= cur_blank;
            end else if (bcnt_q != '0) begin
                bcnt_q <= bcnt_q - BL_W'(1);
            end

            if (start && ov_ext && state_q == RUN) begin
                ovr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_tim_lcar_gen.sv
// Directed bench for out_tim_lcar_gen: table of frame configurations plus reset, overrun and free-run sequences.
module tb_out_tim_lcar_gen;

    localparam int PN_W = 11;
    localparam int PL_W = 12;
    localparam int BL_W = 7;
    localparam int WD_W = 20;

    logic            clk, rst_n, frame_alt;
    logic [PN_W-1:0] period_num_m1, long_num;
    logic [PL_W-1:0] period_len;
    logic [BL_W-1:0] blank_len;
    logic [WD_W-1:0] wd_limit;
    logic            ov_stp, ovt, blanka, period_stb, frame_done, ovr_err, freerun;
    logic [PN_W-1:0] period_idx;

    int tests  = 0;
    int errors = 0;
    int stb_pos[16];
    int n_stb;

    typedef struct {
        int pn;
        int plen;
        int lng;
        int blk;
        int exp_done;
        int exp_stb;
        int exp_blank;
        int exp_ovt;
    } vec_t;

    vec_t vecs[6];

    out_tim_lcar_gen #(.PN_W(PN_W), .PL_W(PL_W), .BL_W(BL_W), .WD_W(WD_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_alt(frame_alt),
        .period_num_m1(period_num_m1), .period_len(period_len), .long_num(long_num),
        .blank_len(blank_len), .wd_limit(wd_limit),
        .ov_stp(ov_stp), .ovt(ovt), .blanka(blanka), .period_stb(period_stb),
        .period_idx(period_idx), .frame_done(frame_done), .ovr_err(ovr_err), .freerun(freerun)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int pn, input int plen, input int lng, input int blk);
        period_num_m1 = PN_W'(pn);
        period_len    = PL_W'(plen);
        long_num      = PN_W'(lng);
        blank_len     = BL_W'(blk);
    endtask

    task automatic toggle();
        @(negedge clk);
        frame_alt = ~frame_alt;
    endtask

    // Returns the number of negedges until ov_stp is seen (bounded).
    task automatic wait_start(output int lat);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (ov_stp) break;
        end
    endtask

    task automatic wait_ov(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov_stp && n < bound);
    endtask

    // Cycle 0 is the ov_stp clock; measures until frame is done and blanking has drained.
    task automatic run_frame(output int lat, output int done_cyc, output int blank_n,
                             output int ovt_n, output int idx_end);
        toggle();
        wait_start(lat);
        n_stb    = 0;
        done_cyc = -1;
        blank_n  = 0;
        ovt_n    = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (ovt) ovt_n++;
            if (blanka) blank_n++;
            if (period_stb && n_stb < 16) begin
                stb_pos[n_stb] = cyc;
                n_stb++;
            end
            if (cyc > 0 && frame_done && done_cyc < 0) done_cyc = cyc;
            if (cyc > 0 && frame_done && !blanka) break;
            @(negedge clk);
        end
        idx_end = int'(period_idx);
    endtask

    initial begin
        int lat, done_cyc, blank_n, ovt_n, idx_end, n, bad;

        // pn, plen, long, blank, done clock, stb count, blank clocks, ovt clocks
        vecs[0] = '{3, 10, 1,  4, 42, 4, 16, 22};
        vecs[1] = '{0,  5, 0,  0,  6, 1,  0,  6};
        vecs[2] = '{2, 10, 0, 15, 31, 3, 35, 21};
        vecs[3] = '{1,  1, 0,  1,  5, 2,  2,  5};
        vecs[4] = '{2,  3, 5,  0, 13, 3,  0,  9};
        vecs[5] = '{1,  0, 1,  2,  6, 2,  4,  6};

        rst_n     = 1'b0;
        frame_alt = 1'b0;
        wd_limit  = '0;
        set_cfg(3, 10, 1, 4);
        repeat (3) @(negedge clk);
        check("rst_frame_done", frame_done, 1);
        check("rst_ov_stp", ov_stp, 0);
        check("rst_ovt", ovt, 0);
        check("rst_blanka", blanka, 0);
        check("rst_period_stb", period_stb, 0);
        check("rst_period_idx", period_idx, 0);
        check("rst_ovr_err", ovr_err, 0);
        check("rst_freerun", freerun, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_start", ov_stp, 0);

        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i].pn, vecs[i].plen, vecs[i].lng, vecs[i].blk);
            run_frame(lat, done_cyc, blank_n, ovt_n, idx_end);
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_done_clk", i), done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_stb_count", i), n_stb, vecs[i].exp_stb);
            check($sformatf("v%0d_first_stb", i), stb_pos[0], 1);
            check($sformatf("v%0d_blank_clks", i), blank_n, vecs[i].exp_blank);
            check($sformatf("v%0d_ovt_clks", i), ovt_n, vecs[i].exp_ovt);
            check($sformatf("v%0d_last_idx", i), idx_end, vecs[i].pn);
            check($sformatf("v%0d_ovr_err", i), ovr_err, 0);
        end

        // Period strides with one lengthened period.
        set_cfg(3, 10, 1, 4);
        run_frame(lat, done_cyc, blank_n, ovt_n, idx_end);
        check("stride_0", stb_pos[1] - stb_pos[0], 11);
        check("stride_1", stb_pos[2] - stb_pos[1], 10);
        check("stride_2", stb_pos[3] - stb_pos[2], 10);

        // Asynchronous reset in the middle of period 2 (blank active).
        toggle();
        wait_start(lat);
        repeat (14) @(negedge clk);
        check("mid_idx_before_rst", period_idx, 1);
        check("mid_blank_before_rst", blanka, 1);
        #5;
        rst_n     = 1'b0;
        frame_alt = 1'b0;
        #1;
        check("mid_rst_frame_done", frame_done, 1);
        check("mid_rst_ovt", ovt, 0);
        check("mid_rst_blanka", blanka, 0);
        check("mid_rst_period_idx", period_idx, 0);
        check("mid_rst_period_stb", period_stb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ov_stp || period_stb || !frame_done || blanka) bad++;
        end
        check("post_rst_quiet", bad, 0);

`ifdef OUT_TIM_FREERUN_EN
        set_cfg(3, 10, 1, 4);
        wd_limit = WD_W'(100);
        wait_ov(300, n);
        check("fr_first_start", ov_stp, 1);
        check("fr_set", freerun, 1);
        wait_ov(300, n);
        check("fr_period_a", n, 100);
        wait_ov(300, n);
        check("fr_period_b", n, 100);
        check("fr_still_set", freerun, 1);
        check("fr_no_ovr", ovr_err, 0);
        repeat (5) @(negedge clk);
        toggle();
        wait_start(lat);
        check("fr_ext_latency", lat, 2);
        check("fr_cleared", freerun, 0);
        @(negedge clk);
        check("fr_ext_no_ovr", ovr_err, 0);
        check("fr_ext_restart_idx", period_idx, 0);
        wd_limit = '0;
`else
        wd_limit = WD_W'(100);
        bad = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (ov_stp || freerun) bad++;
        end
        check("no_fr_quiet", bad, 0);
        wd_limit = '0;
`endif
        n = 0;
        while (!(frame_done && !blanka) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_ovr_idle", frame_done, 1);
        check("pre_ovr_err", ovr_err, 0);

        // Overrun: second toggle 20 clocks into a 41-clock frame.
        set_cfg(3, 10, 1, 4);
        toggle();
        wait_start(lat);
        repeat (20) @(negedge clk);
        toggle();
        wait_start(lat);
        check("ovr_latency", lat, 2);
        @(negedge clk);
        check("ovr_restart_stb", period_stb, 1);
        check("ovr_restart_idx", period_idx, 0);
        check("ovr_set", ovr_err, 1);
        n = 1;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ovr_frame_len", n, 42);
        repeat (10) @(negedge clk);
        check("ovr_sticky", ovr_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/out_tim_lcar_gen.md
Name: out_tim_lcar_gen

Overview:
Parametrised successor of the LED receiver-board output timing generator. Detects a frame toggle and produces the frame start pulse (ov_stp), the first-period flag (ovt), a per-period blanking pulse (blanka) and period status for one frame. Period count, base period length, count of lengthened periods and blank length are run-time inputs; all are latched per frame. Sits between the frame receiver / period-data generator and the MBI5051B driver interface.

Parameters:
PN_W, 11, width of period count/index (max 2^PN_W periods per frame)
PL_W, 12, width of period length counter (clocks)
BL_W, 7, width of blank length counter
WD_W, 20, width of free-run watchdog counter

Ports:
clk  in  1  system clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
frame_alt  in  1  frame toggle; each edge starts a frame
period_num_m1  in  PN_W  periods per frame minus 1
period_len  in  PL_W  base period length in clocks
long_num  in  PN_W  number of leading periods lengthened by 1 clock
blank_len  in  BL_W  blank pulse length in clocks; 0 = no blank
wd_limit  in  WD_W  free-run frame length in clocks; 0 = disabled
ov_stp  out  1  one-clock frame start pulse
ovt  out  1  high from frame start to end of period 1
blanka  out  1  blanking output
period_stb  out  1  one-clock pulse at start of each period
period_idx  out  PN_W  index of current period
frame_done  out  1  high after last period until next start
ovr_err  out  1  sticky: start arrived while frame still running
freerun  out  1  frame timing self-generated (optional feature)

Behaviour:
- Reset (async, rst_n=0): sync regs, ov_stp, ovt, blanka, period_stb, period_idx, ovr_err, freerun = 0; frame_done = 1; state IDLE.
- Frame detect: frame_alt -> fa_1d -> fa_2d. ov_stp registered = fa_1d ^ fa_2d. ov_stp is high exactly one clock, 2 clocks after frame_alt is first sampled changed. If frame_alt=1 at reset release, one ov_stp is generated (intended).
- On ov_stp, shadow-latch period_num_m1, period_len (values <2 clamp to 2), long_num, blank_len. Mid-frame input changes apply from the next frame only.
- States: IDLE, RUN. ov_stp in either state -> RUN, period_idx=0, length counter loaded, frame_done=0, ovt=1.
- Period k length = period_len + (k < long_num ? 1 : 0). Frame length = N*period_len + min(long_num, N), with N = period_num_m1+1.
- Down-counter runs from length-1 to 0. At 0: if period_idx == period_num_m1 -> IDLE, frame_done=1 next clock; else period_idx+1 and reload.
- period_stb registered: high in the clock after ov_stp and in the clock after each non-final period end. Stride between pulses equals the period length.
- ovt cleared when period 1 ends. If N=1, ovt clears at frame end.
- blanka: blank counter loaded with blank_len on each period_stb. blanka=1 while counter nonzero; counter decrements. A reload during an active blank restarts it, so blank_len >= period length gives continuous blanka. After frame end an active blank completes; no new blank in IDLE.
- Simultaneous ov_stp and period end: ov_stp wins and the frame restarts.
- ov_stp while RUN (not yet frame_done): restart as above and set ovr_err. ovr_err clears only on reset.
- Counters never wrap: the length counter stops at 0 in IDLE, and period_idx holds its last value in IDLE.

Optional Feature:
OUT_TIM_FREERUN_EN defined: a watchdog counts clocks since the last ov_stp. When wd_limit != 0 and the count reaches wd_limit-1, an internal one-clock ov_stp is generated, the watchdog restarts and freerun=1. freerun stays set through following self-generated frames. The next frame_alt edge clears freerun, and that external edge does not set ovr_err. Internal starts never set ovr_err.
Not defined: no watchdog logic; wd_limit is ignored; freerun is tied to 0.

Test Plan:
- Reset, frame_alt toggle, period_num_m1=3, period_len=10, long_num=1, blank_len=4 -> ov_stp 1 clk; period_stb strides 11,10,10; frame_done after 41 clks; blanka 4 clks at each period start.
- Same config, assert rst_n=0 mid-period 2 -> all outputs reset immediately; frame_done=1; nothing resumes until the next frame_alt edge.
- period_num_m1=0, period_len=5 -> single period_stb; ovt high 6 clks incl. start; frame_done after 5 clks.
- frame_alt toggled again after 20 clks of a 41-clk frame -> restart at period_idx=0; ovr_err=1 and stays set.
- blank_len=15, period_len=10 -> blanka continuous from first period_stb, ends 15 clks after last period_stb; period_len=1 behaves as 2.
- OUT_TIM_FREERUN_EN, wd_limit=100, no toggles -> internal ov_stp every 100 clks, freerun=1; next external toggle -> freerun=0, ovr_err unchanged.
